// File: rtl/pipe_pkg.sv
// Shared types and helpers for the forwarding pipeline chain.
package pipe_pkg;

  // Write-back tag carried alongside each slot's opaque payload.
  typedef struct packed {
    logic [1:0]  rw;    // 00 no write; rw[1] selects register file (0 int, 1 float)
    logic [4:0]  rd;    // destination index
    logic [31:0] d;     // result value
    logic        d_ok;  // d is final
  } wb_tag_t;

  localparam logic [1:0] RW_NONE = 2'b00;

  // Tag/source match, ignoring slot valid and the hard-wired zero register.
  function automatic logic fwd_match(input wb_tag_t t, input logic [5:0] src);
    return (t.rw != RW_NONE) && (t.rw[1] == src[5]) && (t.rd == src[4:0]);
  endfunction

  // Late result merged into a tag: value becomes final.
  function automatic wb_tag_t apply_upd(input wb_tag_t t, input logic [31:0] d);
    wb_tag_t r;
    r      = t;
    r.d    = d;
    r.d_ok = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/pipe_fwd_slot.sv
// One pipeline slot: load from upstream, hold, kill on flush, absorb a late result.
module pipe_fwd_slot
  import pipe_pkg::*;
#(
  parameter int PW = 64
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          flush,
  input  logic          load,        // slot takes whatever upstream offers this edge
  input  logic          in_vld,      // upstream has an entry to hand over
  input  logic [PW-1:0] in_payload,
  input  wb_tag_t       in_tag,      // upstream tag, already carrying any same-edge update
  input  logic          upd_en,      // late result targets this slot's current entry
  input  logic [31:0]   upd_d,
  output logic          vld,
  output logic [PW-1:0] payload,
  output wb_tag_t       tag
);

  // Slot state: flush kills, load replaces (or vacates), otherwise hold and take a late result.
  // When the entry moves on the same edge as its update, the downstream slot receives the
  // merged tag through in_tag, so only the holding case is handled here.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld     <= 1'b0;
      payload <= '0;
      tag     <= '0;
    end else if (flush) begin
      vld <= 1'b0;
    end else if (load) begin
      vld <= in_vld;
      if (in_vld) begin
        payload <= in_payload;
        tag     <= in_tag;
      end
    end else if (upd_en && vld) begin
      tag <= apply_upd(tag, upd_d);
    end
  end

endmodule

// File: rtl/pipe_fwd_chain.sv
// NSTG-deep valid/ready register chain with bubble collapse, flush, late-result update
// and multi-source operand forwarding with pending-result detection.
module pipe_fwd_chain
  import pipe_pkg::*;
#(
  parameter int NSTG    = 3,
  parameter int PW      = 64,
  parameter int NSRC    = 2,
  parameter int ZERO_HW = 1,
  localparam int UW     = (NSTG > 1) ? $clog2(NSTG) : 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PW-1:0]              in_payload,
  input  logic [1:0]                 in_rw,
  input  logic [4:0]                 in_rd,
  input  logic [31:0]                in_d,
  input  logic                       in_d_ok,
  input  logic                       upd_valid,
  input  logic [UW-1:0]              upd_idx,
  input  logic [31:0]                upd_d,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PW-1:0]              out_payload,
  output logic [1:0]                 out_rw,
  output logic [4:0]                 out_rd,
  output logic [31:0]                out_d,
  output logic                       out_d_ok,
  input  logic [NSRC-1:0][5:0]       src_reg,
  input  logic [NSRC-1:0][31:0]      src_val,
  output logic [NSRC-1:0][31:0]      fwd_val,
  output logic [NSRC-1:0]            fwd_hit,
  output logic [NSRC-1:0]            fwd_pend
);

  logic [NSTG-1:0]          vld;
  logic [NSTG-1:0]          ld;
  logic [NSTG-1:0]          upd_en;
  logic [NSTG-1:0][PW-1:0]  pl;
  wb_tag_t [NSTG-1:0]       tag;

  // Per-slot upstream view (entry offered to slot i).
  logic                     s_in_vld [NSTG];
  logic [PW-1:0]            s_in_pl  [NSTG];
  wb_tag_t                  s_in_tag [NSTG];

  wb_tag_t                  in_tag;

  // Pack the entry's write-back fields.
  always_comb begin
    in_tag      = '0;
    in_tag.rw   = in_rw;
    in_tag.rd   = in_rd;
    in_tag.d    = in_d;
    in_tag.d_ok = in_d_ok;
  end

  // Ready chain: slot i loads unless it and every slot downstream are full while the
  // consumer stalls. Written without self-reference so it stays a flat combinational cone.
  always_comb begin
    ld = '0;
    for (int i = 0; i < NSTG; i++) begin
      logic full;
      full = 1'b1;
      for (int j = i; j < NSTG; j++) full = full & vld[j];
      ld[i] = out_ready || !full;
    end
  end

  assign in_ready = ld[0] && !flush;

  // Late-result targeting; out-of-range indices simply match no slot.
  always_comb begin
    upd_en = '0;
    for (int i = 0; i < NSTG; i++)
      upd_en[i] = upd_valid && vld[i] && (upd_idx == UW'(i));
  end

  genvar g;
  generate
    for (g = 0; g < NSTG; g++) begin : g_slot
      if (g == 0) begin : g_head
        assign s_in_vld[g] = in_valid && in_ready;
        assign s_in_pl[g]  = in_payload;
        assign s_in_tag[g] = in_tag;
      end else begin : g_body
        // The update rides along when the upstream entry moves this edge.
        assign s_in_vld[g] = vld[g-1];
        assign s_in_pl[g]  = pl[g-1];
        assign s_in_tag[g] = upd_en[g-1] ? apply_upd(tag[g-1], upd_d) : tag[g-1];
      end

      pipe_fwd_slot #(.PW(PW)) u_slot (
        .clk        (clk),
        .rstn       (rstn),
        .flush      (flush),
        .load       (ld[g]),
        .in_vld     (s_in_vld[g]),
        .in_payload (s_in_pl[g]),
        .in_tag     (s_in_tag[g]),
        .upd_en     (upd_en[g]),
        .upd_d      (upd_d),
        .vld        (vld[g]),
        .payload    (pl[g]),
        .tag        (tag[g])
      );
    end
  endgenerate

  assign out_valid   = vld[NSTG-1];
  assign out_payload = pl[NSTG-1];
  assign out_rw      = tag[NSTG-1].rw;
  assign out_rd      = tag[NSTG-1].rd;
  assign out_d       = tag[NSTG-1].d;
  assign out_d_ok    = tag[NSTG-1].d_ok;

  // Forward mux: scan oldest to youngest so the lowest-index match overrides.
  always_comb begin
    fwd_val  = src_val;
    fwd_hit  = '0;
    fwd_pend = '0;
    for (int s = 0; s < NSRC; s++) begin
      for (int i = NSTG - 1; i >= 0; i--) begin
        if (vld[i] && fwd_match(tag[i], src_reg[s]) &&
            !((ZERO_HW != 0) && (src_reg[s] == 6'd0))) begin
          fwd_val[s]  = tag[i].d;
          fwd_hit[s]  = 1'b1;
          fwd_pend[s] = !tag[i].d_ok;
        end
      end
    end
  end

endmodule
